// File: rtl/ps2_key_event_fifo_if.sv
// Bus between the PS/2 byte source / event consumer and ps2_key_event_fifo.
// The master side drives received bytes and pops; the slave side returns the queued key events.
interface ps2_key_event_fifo_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             flag;
    logic [7:0]       scancode;
    logic             rd_en;
    logic             ev_valid;
    logic [7:0]       ev_code;
    logic             ev_ext;
    logic             ev_break;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             held;

    modport master (
        output flag, scancode, rd_en,
        input  ev_valid, ev_code, ev_ext, ev_break, count, overflow, held
    );

    modport slave (
        input  flag, scancode, rd_en,
        output ev_valid, ev_code, ev_ext, ev_break, count, overflow, held
    );
endinterface

// File: rtl/ps2_key_event_fifo.sv
// Parses set-2 PS/2 bytes (E0/F0 prefixes) into make/break key events and queues them
// in a show-ahead FIFO, with optional suppression of typematic repeats of the held key.
module ps2_key_event_fifo #(
    parameter int unsigned DEPTH         = 4,
    parameter bit          FILTER_REPEAT = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    ps2_key_event_fifo_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    logic             r_flag_d;
    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             w_accept;
    logic             w_emit;
    logic             w_housekeep;
    ev_t              w_ev;

    logic             r_held;
    logic             r_last_ext;
    logic [7:0]       r_last_code;
    logic             w_match;
    logic             w_filtered;
    logic             w_wr;
    logic             w_held_next;
    logic             w_last_ext_next;
    logic [7:0]       w_last_code_next;

    ev_t              r_mem [DEPTH];
    ev_t              w_mem_next [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_wr_next;
    logic [PTR_W-1:0] w_rd_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_overflow_next;
    ev_t              r_head;
    ev_t              w_head_next;
    logic             r_valid;

    assign w_accept    = bus.flag & ~r_flag_d;
    assign w_housekeep = (bus.scancode == 8'h00) || (bus.scancode == 8'hAA) ||
                         (bus.scancode == 8'hFA) || (bus.scancode == 8'hFE) ||
                         (bus.scancode == 8'hEE) || (bus.scancode == 8'hFF);

    // Prefix parser: decides state and whether the accepted byte completes an event
    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_ev.ext     = 1'b0;
        w_ev.brk     = 1'b0;
        w_ev.code    = bus.scancode;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.scancode == 8'hE0)      w_state_next = ST_EXT;
                    else if (bus.scancode == 8'hF0) w_state_next = ST_BRK;
                    else if (!w_housekeep)          w_emit       = 1'b1;
                end
                ST_EXT: begin
                    if (bus.scancode == 8'hF0) begin
                        w_state_next = ST_EXT_BRK;
                    end else if (bus.scancode != 8'hE0) begin
                        w_emit       = 1'b1;
                        w_ev.ext     = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_state_next = ST_IDLE;
                    if (bus.scancode != 8'hE0 && bus.scancode != 8'hF0) begin
                        w_emit   = 1'b1;
                        w_ev.brk = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    if (bus.scancode != 8'hE0 && bus.scancode != 8'hF0) begin
                        w_emit   = 1'b1;
                        w_ev.ext = 1'b1;
                        w_ev.brk = 1'b1;
                    end
                end
            endcase
        end
    end

    // Held-key tracker and repeat filter
    always_comb begin
        w_match          = (w_ev.ext == r_last_ext) && (w_ev.code == r_last_code);
        w_filtered       = FILTER_REPEAT && w_emit && !w_ev.brk && r_held && w_match;
        w_wr             = w_emit && !w_filtered;
        w_held_next      = r_held;
        w_last_ext_next  = r_last_ext;
        w_last_code_next = r_last_code;
        if (w_emit && !w_ev.brk) begin
            w_held_next      = 1'b1;
            w_last_ext_next  = w_ev.ext;
            w_last_code_next = w_ev.code;
        end else if (w_emit && w_ev.brk && w_match) begin
            w_held_next = 1'b0;
        end
    end

    // FIFO next state; a full FIFO still accepts a write when the same edge pops
    always_comb begin
        w_full          = (r_count == CNT_W'(DEPTH));
        w_empty         = (r_count == '0);
        w_pop           = bus.rd_en && !w_empty;
        w_push          = w_wr && (!w_full || w_pop);
        w_overflow_next = w_wr && w_full && !w_pop;
        w_mem_next      = r_mem;
        w_wr_next       = r_wr_ptr;
        w_rd_next       = r_rd_ptr;
        w_cnt_next      = r_count;
        if (w_push) begin
            w_mem_next[r_wr_ptr] = w_ev;
            w_wr_next            = PTR_W'(r_wr_ptr + PTR_W'(1));
        end
        if (w_pop) begin
            w_rd_next = PTR_W'(r_rd_ptr + PTR_W'(1));
        end
        if (w_push && !w_pop)      w_cnt_next = CNT_W'(r_count + CNT_W'(1));
        else if (w_pop && !w_push) w_cnt_next = CNT_W'(r_count - CNT_W'(1));
        w_head_next = (w_cnt_next != '0) ? w_mem_next[w_rd_next] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flag_d    <= 1'b0;
            r_state     <= ST_IDLE;
            r_held      <= 1'b0;
            r_last_ext  <= 1'b0;
            r_last_code <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_head      <= '0;
            bus.overflow <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else begin
            r_flag_d    <= bus.flag;
            r_state     <= w_state_next;
            r_held      <= w_held_next;
            r_last_ext  <= w_last_ext_next;
            r_last_code <= w_last_code_next;
            r_wr_ptr    <= w_wr_next;
            r_rd_ptr    <= w_rd_next;
            r_count     <= w_cnt_next;
            r_valid     <= (w_cnt_next != '0);
            r_head      <= w_head_next;
            if (w_overflow_next) bus.overflow <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= w_mem_next[i];
        end
    end

    assign bus.ev_valid = r_valid;
    assign bus.ev_code  = r_head.code;
    assign bus.ev_ext   = r_head.ext;
    assign bus.ev_break = r_head.brk;
    assign bus.count    = r_count;
    assign bus.held     = r_held;
endmodule
